cacheline_adapter: RTL and testbench

//  Sits directly below the cache's downward-facing port (dfp). Converts each 256-bit line

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cacheline_adapter.sv | 133 +++++++++++++
 tb/tb_cacheline_adapter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side line adapter: line/beat geometry, the adapter state
// encoding and a helper that aligns a byte address to its cache line.
package cache_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BEATS       = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned CNT_W       = $clog2(BEATS);
  localparam int unsigned BEAT_SH     = $clog2(BEAT_W);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrBurst,
    StResp
  } adapter_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  // Clear the in-line byte offset so the burst starts on the line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] res;
    res                    = addr;
    res[OFFSET_BITS-1:0]   = '0;
    return res;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Width/protocol converter below the cache's downward-facing port. Each 256-bit line read or
// write becomes a 4-beat x 64-bit burst on the memory port; one dfp_resp pulse per line.
// One transaction in flight, no reordering.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   dfp_addr/read/write line request from the cache, held until dfp_resp
//   dfp_wdata           line to write, held until dfp_resp
//   dfp_rdata           assembled read line, holds until the next read completes
//   dfp_resp            one-cycle completion pulse
//   mem_addr            line-aligned burst base address
//   mem_read            read command, held until mem_ready
//   mem_write/mem_wdata write beat valid and data, a beat advances on mem_ready
//   mem_ready           memory accepts the command or beat this cycle
//   mem_rdata/rvalid    read beats, always accepted
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  adapter_state_t            state_q;
  logic [CNT_W-1:0]          beat_cnt_q;
  logic [ADDR_W-1:0]         addr_q;
  line_t                     line_q;   // shared by read assembly and write serialisation
  line_t                     rdata_q;  // separate so reads survive intervening writes
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic                      dfp_resp_q;

  logic [CNT_W+BEAT_SH-1:0]  beat_base;
  line_t                     rd_line;

  assign beat_base = {beat_cnt_q, BEAT_SH'(0)};

  // Line buffer with the incoming beat merged into its slot.
  always_comb begin
    rd_line                       = line_q;
    rd_line[beat_base +: BEAT_W]  = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      dfp_resp_q  <= 1'b0;
    end else begin
      dfp_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A write wins if the cache raises both.
          if (dfp_write) begin
            addr_q      <= line_align(dfp_addr);
            line_q      <= dfp_wdata;
            beat_cnt_q  <= '0;
            mem_write_q <= 1'b1;
            state_q     <= StWrBurst;
          end else if (dfp_read) begin
            addr_q     <= line_align(dfp_addr);
            mem_read_q <= 1'b1;
            state_q    <= StRdReq;
          end
        end
        StRdReq: begin
          if (mem_ready) begin
            mem_read_q <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= StRdData;
          end
        end
        StRdData: begin
          if (mem_rvalid) begin
            line_q     <= rd_line;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              rdata_q    <= rd_line;
              dfp_resp_q <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StWrBurst: begin
          if (mem_ready) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              mem_write_q <= 1'b0;
              dfp_resp_q  <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StResp: begin
          // Request is not resampled here, so a still-held request cannot double issue.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dfp_rdata = rdata_q;
  assign dfp_resp  = dfp_resp_q;
  assign mem_addr  = addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = line_q[beat_base +: BEAT_W];

  a_no_dual_request: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StIdle) |-> !(dfp_read && dfp_write));

  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StIdle) |-> !mem_rvalid);

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic         mem_ready;
  logic [63:0]  mem_rdata;
  logic         mem_rvalid;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: 32-bit words by byte address; unwritten words read back their own address.
  logic [31:0] mem_w [logic [31:0]];

  function automatic logic [31:0] rd32(input logic [31:0] a);
    if (mem_w.exists(a)) return mem_w[a];
    return a;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rd32(align(a) + 32'(4 * i));
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Current transaction as the cache intends it.
  bit           exp_write;
  logic [31:0]  exp_addr;
  logic [255:0] exp_line;

  // Memory behaviour knobs.
  int ready_mode;  // 0 always ready, 1 toggle 1,0, 2 random
  bit rtog;
  int rd_lat;
  int rd_gap;      // negative: random 0..3

  // Monitor state.
  logic [63:0] rq[$];
  int          rwait;
  int          wcnt, rcmd, rsent, rd_hi, n_rd_cmd, n_resp;
  bit          prev_resp;
  logic [63:0] first_wbeat;
  logic [31:0] cap_addr;

  // Memory responder and compare process.
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rtog = 1'b0; rwait = 0; wcnt = 0; rcmd = 0; rsent = 0; rd_hi = 0;
    n_rd_cmd = 0; n_resp = 0; prev_resp = 1'b0; first_wbeat = '0; cap_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_ctl", {mem_read, mem_write, dfp_resp}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_rdata", dfp_rdata, 0);
        rq.delete();
        mem_rvalid = 1'b0;
        wcnt = 0; rcmd = 0; rsent = 0; prev_resp = 1'b0;
      end else begin
        if (dfp_resp) begin
          chk("resp_width", prev_resp, 0);
          chk("resp_quiet", {mem_read, mem_write}, 0);
          if (exp_write) begin
            chk("wr_beats", wcnt, 4);
          end else begin
            chk("rd_cmds", rcmd, 1);
            chk("rd_beats", rsent, 4);
            chk("rd_line", dfp_rdata, model_line(exp_addr));
          end
          n_resp++;
          wcnt = 0; rcmd = 0; rsent = 0;
        end
        prev_resp = dfp_resp;

        case (ready_mode)
          0:       mem_ready = 1'b1;
          1:       begin mem_ready = ~rtog; rtog = ~rtog; end
          default: mem_ready = 1'($urandom_range(0, 1));
        endcase

        if (mem_write) begin
          chk("wr_addr", mem_addr, align(exp_addr));
          if (mem_ready) begin
            chk("wr_overrun", wcnt < 4, 1);
            if (wcnt < 4) begin
              if (wcnt == 0) first_wbeat = mem_wdata;
              chk("wr_beat", mem_wdata, exp_line[wcnt*64 +: 64]);
              mem_w[mem_addr + 32'(wcnt * 8)]     = mem_wdata[31:0];
              mem_w[mem_addr + 32'(wcnt * 8 + 4)] = mem_wdata[63:32];
            end
            wcnt++;
          end
        end

        if (rq.size() > 0) begin
          if (rwait > 0) begin
            rwait--;
            mem_rvalid = 1'b0;
          end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq.pop_front();
            rsent++;
            rwait = (rd_gap < 0) ? $urandom_range(0, 3) : rd_gap;
          end
        end else begin
          mem_rvalid = 1'b0;
        end

        if (mem_read) begin
          rd_hi++;
          chk("rd_addr", mem_addr, align(exp_addr));
          if (mem_ready) begin
            cap_addr = mem_addr;
            rcmd++;
            n_rd_cmd++;
            for (int b = 0; b < 4; b++)
              rq.push_back({rd32(mem_addr + 32'(8 * b + 4)), rd32(mem_addr + 32'(8 * b))});
            rwait = rd_lat;
          end
        end
      end
    end
  end

  // One line transaction; lat counts cycles from request presentation to dfp_resp.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] line,
                     input bit scramble, output int lat);
    bit got;
    @(posedge clk); #1;
    exp_write = wr; exp_addr = a; exp_line = line;
    dfp_addr  = a;
    dfp_wdata = wr ? line : rand_line();
    dfp_write = wr;
    dfp_read  = !wr;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (dfp_resp) got = 1'b1;
      else if (scramble && k == 1) begin
        dfp_addr  = $urandom;
        dfp_wdata = rand_line();
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
    @(posedge clk); #1;
    dfp_read = 1'b0; dfp_write = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (dfp_resp) got = 1'b1;
    end
    if (!got) chk(name, 0, 1);
  endtask

  logic [255:0] line3, line6;
  int lat, base_cmd, base_resp;
  bit hit;

  initial begin
    rst = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    exp_write = 1'b0; exp_addr = '0; exp_line = '0;
    ready_mode = 0; rd_lat = 0; rd_gap = 0;
    for (int i = 0; i < 8; i++) begin
      line3[i*32 +: 32] = 32'hBEB0_0000 + 32'(i);
      line6[i*32 +: 32] = 32'hCAFE_0000 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Zero-wait read of 0x404.
    rd_hi = 0;
    txn(1'b0, 32'h0000_0404, '0, 1'b0, lat);
    chk("t2_latency", lat, 7);
    chk("t2_word0", dfp_rdata[31:0], 32'h0000_0400);
    chk("t2_word7", dfp_rdata[255:224], 32'h0000_041C);
    chk("t2_mem_addr", cap_addr, 32'h0000_0400);
    chk("t2_read_cycles", rd_hi, 1);

    // Write with mem_ready toggling.
    ready_mode = 1; rtog = 1'b0;
    txn(1'b1, 32'h0000_0800, line3, 1'b0, lat);
    chk("t3_beat0", first_wbeat, 64'hBEB0_0001_BEB0_0000);
    chk("t3_mem_line", model_line(32'h0000_0800), line3);

    // Zero-wait write latency.
    ready_mode = 0;
    txn(1'b1, 32'h0000_0900, rand_line(), 1'b0, lat);
    chk("t3_wr_latency", lat, 6);

    // Read with 3-cycle gaps between beats.
    rd_lat = 2; rd_gap = 3;
    txn(1'b0, 32'h0000_0810, '0, 1'b0, lat);
    chk("t4_line", dfp_rdata, line3);

    // Reset in the middle of a read burst.
    rd_lat = 0; rd_gap = 0;
    @(posedge clk); #1;
    exp_write = 1'b0; exp_addr = 32'h0000_2000; dfp_addr = 32'h0000_2000; dfp_read = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(posedge clk);
      if (rsent == 2) hit = 1'b1;
    end
    chk("t1_reach_beat2", hit, 1);
    #2 rst = 1'b0; dfp_read = 1'b0;
    #1;
    chk("t1_rst_ctl", {mem_read, mem_write, dfp_resp}, 0);
    chk("t1_rst_rdata", dfp_rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    txn(1'b0, 32'h0000_3004, '0, 1'b0, lat);
    chk("t1_fresh_word0", dfp_rdata[31:0], 32'h0000_3000);
    chk("t1_fresh_word3", dfp_rdata[127:96], 32'h0000_300C);

    // Request held for two cycles past dfp_resp: exactly one more burst.
    base_cmd = n_rd_cmd; base_resp = n_resp;
    @(posedge clk); #1;
    exp_write = 1'b0; exp_addr = 32'h0000_4000; dfp_addr = 32'h0000_4000; dfp_read = 1'b1;
    wait_resp("t5_resp1_timeout");
    repeat (3) @(posedge clk);
    #1 dfp_read = 1'b0;
    wait_resp("t5_resp2_timeout");
    repeat (20) @(posedge clk);
    chk("t5_read_cmds", n_rd_cmd - base_cmd, 2);
    chk("t5_resps", n_resp - base_resp, 2);

    // Back-to-back write then read of 0x8400.
    ready_mode = 2; rd_gap = -1;
    txn(1'b1, 32'h0000_8400, line6, 1'b0, lat);
    txn(1'b0, 32'h0000_8400, '0, 1'b0, lat);
    chk("t6_roundtrip", dfp_rdata, line6);

    // Randomized traffic over a small set of lines so reads revisit written data.
    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 2);
      rd_lat     = $urandom_range(0, 3);
      rd_gap     = $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 2));
      txn(1'($urandom_range(0, 1)),
          32'h0001_0000 + 32'($urandom_range(0, 7) << 5) + 32'($urandom_range(0, 31)),
          rand_line(), 1'($urandom_range(0, 1)), lat);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
